// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit.
//   brq_entry_t      : one branch_update_queue slot
//   BRQ_DEPTH        : default branch_update_queue depth
//   brq_mispredicted : direction check applied at retire
package bpu_pkg;

    localparam int unsigned BRQ_DEPTH  = 8;
    localparam int unsigned BRQ_ADDR_W = 32;

    // One in-flight branch: PC, prediction, resolution and occupancy
    typedef struct packed {
        logic [BRQ_ADDR_W-1:0] addr;
        logic                  pred_valid;
        logic                  pred_taken;
        logic                  resolved;
        logic                  taken;
        logic                  busy;
    } brq_entry_t;

    // An invalid prediction counts as predicted not-taken
    function automatic logic brq_mispredicted(input brq_entry_t e);
        return e.taken != (e.pred_valid & e.pred_taken);
    endfunction

endpackage

// File: rtl/branch_update_queue.sv
// In-order tracking queue for predicted branches.
// Fetch allocates entries at the tail, execute resolves them out of order by
// tag, and resolved entries retire from the head in program order, producing
// one BPU training update (plus a mispredict pulse when the direction was
// wrong) per retired entry.
//   clk, rst                : clock, synchronous active-high reset
//   alloc_valid/alloc_ready : allocation handshake; alloc_tag is the tail slot
//   alloc_addr/alloc_pred_* : PC and BPU prediction of the new entry
//   resolve_valid/_tag/_taken : out-of-order resolution from execute
//   flush                   : drop every entry, pointers back to zero
//   update_*                : registered BPU training strobe and payload
//   mispredict_*            : registered mispredict pulse and PC
//   count                   : occupied entries
module branch_update_queue
    import bpu_pkg::*;
#(
    parameter  int unsigned DEPTH = BRQ_DEPTH,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [BRQ_ADDR_W-1:0] alloc_addr,
    input  logic                  alloc_pred_valid,
    input  logic                  alloc_pred_taken,
    output logic [TAG_W-1:0]      alloc_tag,

    input  logic                  resolve_valid,
    input  logic [TAG_W-1:0]      resolve_tag,
    input  logic                  resolve_taken,

    input  logic                  flush,

    output logic                  update_valid,
    output logic [BRQ_ADDR_W-1:0] update_addr,
    output logic                  update_taken,

    output logic                  mispredict_valid,
    output logic [BRQ_ADDR_W-1:0] mispredict_addr,

    output logic [TAG_W:0]        count
);

    localparam int unsigned PTR_W = TAG_W + 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    brq_entry_t       entries [DEPTH];

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    brq_entry_t       head_entry;
    logic             full;
    logic             alloc_fire;
    logic             resolve_fire;
    logic             retire_fire;

    // Status and event decode; full/retire depend on registered state only
    always_comb begin
        head_idx     = head[TAG_W-1:0];
        tail_idx     = tail[TAG_W-1:0];
        head_entry   = entries[head_idx];
        full         = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
        alloc_fire   = alloc_valid && !full && !flush;
        resolve_fire = resolve_valid && entries[resolve_tag].busy && !flush;
        retire_fire  = head_entry.busy && head_entry.resolved && !flush;
    end

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign count       = tail - head;

    // Head/tail pointers
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (retire_fire) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    // Entry storage. Alloc and retire never target the same slot: a full
    // queue blocks alloc and an empty head slot cannot retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i].busy <= 1'b0;
            end
        end else begin
            if (resolve_fire) begin
                entries[resolve_tag].resolved <= 1'b1;
                entries[resolve_tag].taken    <= resolve_taken;
            end
            if (retire_fire) begin
                entries[head_idx].busy <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail_idx] <= '{
                    addr:       alloc_addr,
                    pred_valid: alloc_pred_valid,
                    pred_taken: alloc_pred_taken,
                    resolved:   1'b0,
                    taken:      1'b0,
                    busy:       1'b1
                };
            end
        end
    end

    // Retire outputs; payloads hold their last value while the strobes are low
    always_ff @(posedge clk) begin
        if (rst) begin
            update_valid     <= 1'b0;
            update_addr      <= '0;
            update_taken     <= 1'b0;
            mispredict_valid <= 1'b0;
            mispredict_addr  <= '0;
        end else begin
            update_valid     <= retire_fire;
            mispredict_valid <= retire_fire && brq_mispredicted(head_entry);
            if (retire_fire) begin
                update_addr  <= head_entry.addr;
                update_taken <= head_entry.taken;
                if (brq_mispredicted(head_entry)) begin
                    mispredict_addr <= head_entry.addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue (DEPTH=4): directed scenarios
// with literal expectations, then randomized traffic against a queue model.
module tb_branch_update_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [31:0]       alloc_addr;
    logic              alloc_pred_valid;
    logic              alloc_pred_taken;
    logic [TAG_W-1:0]  alloc_tag;
    logic              resolve_valid;
    logic [TAG_W-1:0]  resolve_tag;
    logic              resolve_taken;
    logic              flush;
    logic              update_valid;
    logic [31:0]       update_addr;
    logic              update_taken;
    logic              mispredict_valid;
    logic [31:0]       mispredict_addr;
    logic [TAG_W:0]    count;

    branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_addr       (alloc_addr),
        .alloc_pred_valid (alloc_pred_valid),
        .alloc_pred_taken (alloc_pred_taken),
        .alloc_tag        (alloc_tag),
        .resolve_valid    (resolve_valid),
        .resolve_tag      (resolve_tag),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .update_valid     (update_valid),
        .update_addr      (update_addr),
        .update_taken     (update_taken),
        .mispredict_valid (mispredict_valid),
        .mispredict_addr  (mispredict_addr),
        .count            (count)
    );

    always #5 clk = ~clk;

    // Program-order list of live branches
    typedef struct {
        int unsigned addr;
        bit          pv;
        bit          pt;
        bit          resolved;
        bit          taken;
        int unsigned tag;
    } m_rec_t;

    m_rec_t      m_q[$];
    int unsigned m_next_tag;
    bit          m_uv;
    int unsigned m_uaddr;
    bit          m_ut;
    bit          m_mv;
    int unsigned m_maddr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model
    task automatic compare_all();
        check("alloc_ready", longint'(alloc_ready), longint'(m_q.size() < DEPTH));
        check("alloc_tag", longint'(alloc_tag), longint'(m_next_tag));
        check("count", longint'(count), longint'(m_q.size()));
        check("update_valid", longint'(update_valid), longint'(m_uv));
        if (m_uv) begin
            check("update_addr", longint'(update_addr), longint'(m_uaddr));
            check("update_taken", longint'(update_taken), longint'(m_ut));
        end
        check("mispredict_valid", longint'(mispredict_valid), longint'(m_mv));
        if (m_mv) begin
            check("mispredict_addr", longint'(mispredict_addr), longint'(m_maddr));
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        m_rec_t head;
        bit     retire;
        bit     accept;
        m_uv = 1'b0;
        m_mv = 1'b0;
        if (rst) begin
            m_q.delete();
            m_next_tag = 0;
            m_uaddr = 0;
            m_ut    = 1'b0;
            m_maddr = 0;
            return;
        end
        if (flush) begin
            m_q.delete();
            m_next_tag = 0;
            return;
        end
        retire = (m_q.size() > 0) && m_q[0].resolved;
        accept = alloc_valid && (m_q.size() < DEPTH);
        if (retire) head = m_q[0];
        if (resolve_valid) begin
            foreach (m_q[i]) begin
                if (m_q[i].tag == int'(resolve_tag)) begin
                    m_q[i].resolved = 1'b1;
                    m_q[i].taken    = resolve_taken;
                end
            end
        end
        if (retire) begin
            void'(m_q.pop_front());
            m_uv    = 1'b1;
            m_uaddr = head.addr;
            m_ut    = head.taken;
            if (head.taken != (head.pv && head.pt)) begin
                m_mv    = 1'b1;
                m_maddr = head.addr;
            end
        end
        if (accept) begin
            m_q.push_back('{addr: alloc_addr, pv: alloc_pred_valid, pt: alloc_pred_taken,
                            resolved: 1'b0, taken: 1'b0, tag: m_next_tag});
            m_next_tag = (m_next_tag + 1) % DEPTH;
        end
    endtask

    // Apply inputs for one clock, step the model, then check after the edge
    task automatic cyc(input bit av, input int unsigned addr, input bit pv, input bit pt,
                       input bit rv, input int unsigned rtag, input bit rtk,
                       input bit fl, input bit r);
        alloc_valid      = av;
        alloc_addr       = addr;
        alloc_pred_valid = pv;
        alloc_pred_taken = pt;
        resolve_valid    = rv;
        resolve_tag      = TAG_W'(rtag);
        resolve_taken    = rtk;
        flush            = fl;
        rst              = r;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alloc(input int unsigned addr, input bit pv, input bit pt);
        cyc(1, addr, pv, pt, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int unsigned tag, input bit tk);
        cyc(0, 0, 0, 0, 1, tag, tk, 0, 0);
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_addr = '0; alloc_pred_valid = 1'b0;
        alloc_pred_taken = 1'b0; resolve_valid = 1'b0; resolve_tag = '0;
        resolve_taken = 1'b0; flush = 1'b0;
        m_next_tag = 0; m_uv = 0; m_uaddr = 0; m_ut = 0; m_mv = 0; m_maddr = 0;
        @(negedge clk);

        // Reset state
        do_reset();
        do_reset();
        check("rst_alloc_ready", longint'(alloc_ready), 1);
        check("rst_alloc_tag", longint'(alloc_tag), 0);
        check("rst_count", longint'(count), 0);
        check("rst_update_valid", longint'(update_valid), 0);
        check("rst_mispredict_valid", longint'(mispredict_valid), 0);

        // Single predicted-taken branch, resolved taken: 2-cycle latency
        check("s1_tag", longint'(alloc_tag), 0);
        alloc(32'h100, 1, 1);
        resolve(0, 1);
        check("s1_no_early_update", longint'(update_valid), 0);
        idle();
        check("s1_uv", longint'(update_valid), 1);
        check("s1_uaddr", longint'(update_addr), 32'h100);
        check("s1_utaken", longint'(update_taken), 1);
        check("s1_mv", longint'(mispredict_valid), 0);
        idle();

        // Out-of-order resolve, in-order retire
        do_reset();
        check("s2_tag0", longint'(alloc_tag), 0);
        alloc(32'h200, 1, 0);
        check("s2_tag1", longint'(alloc_tag), 1);
        alloc(32'h204, 1, 1);
        resolve(1, 1);
        idle();
        check("s2_blocked", longint'(update_valid), 0);
        resolve(0, 0);
        idle();
        check("s2_first_uv", longint'(update_valid), 1);
        check("s2_first_addr", longint'(update_addr), 32'h200);
        idle();
        check("s2_second_uv", longint'(update_valid), 1);
        check("s2_second_addr", longint'(update_addr), 32'h204);
        idle();

        // Full queue, ignored alloc, wrap of the tag
        do_reset();
        for (int i = 0; i < 4; i++) alloc(32'h400 + 4 * i, 1, 0);
        check("s3_count_full", longint'(count), 4);
        check("s3_not_ready", longint'(alloc_ready), 0);
        alloc(32'h4f0, 1, 1);
        check("s3_count_after_5th", longint'(count), 4);
        resolve(0, 0);
        idle();
        check("s3_retire_uv", longint'(update_valid), 1);
        check("s3_ready_again", longint'(alloc_ready), 1);
        check("s3_wrap_tag", longint'(alloc_tag), 0);
        alloc(32'h410, 0, 0);
        check("s3_count_refill", longint'(count), 4);

        // Invalid prediction treated as not-taken
        do_reset();
        alloc(32'h300, 0, 1);
        resolve(0, 1);
        idle();
        check("s4_uv", longint'(update_valid), 1);
        check("s4_utaken", longint'(update_taken), 1);
        check("s4_mv", longint'(mispredict_valid), 1);
        check("s4_maddr", longint'(mispredict_addr), 32'h300);

        // Flush in the cycle the head would retire
        do_reset();
        alloc(32'h500, 1, 1);
        alloc(32'h504, 1, 1);
        alloc(32'h508, 1, 1);
        resolve(0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("s5_no_update", longint'(update_valid), 0);
        check("s5_count", longint'(count), 0);
        check("s5_tag", longint'(alloc_tag), 0);
        idle();
        check("s5_still_no_update", longint'(update_valid), 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit          av, rv, fl, r;
            int unsigned rtag;
            av = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 199) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
                rtag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                rtag = $urandom_range(0, DEPTH - 1);
            cyc(av, $urandom & 32'hffff_fffc, 1'($urandom), 1'($urandom),
                rv, rtag, 1'($urandom), fl, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

In-order tracking queue for predicted branches between fetch and the BPU update port. Fetch allocates one entry per control-flow instruction, carrying the PC and the BPU's prediction. Execute resolves entries out of order by tag. The queue retires entries strictly in program order, producing one BPU training update per retired entry and a mispredict pulse when the resolved direction differs from the prediction.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥2
- TAG_W, $clog2(DEPTH), entry tag width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- alloc_valid  in  1  fetch requests a new entry
- alloc_ready  out  1  queue not full; an allocation is accepted when alloc_valid && alloc_ready
- alloc_addr  in  32  branch PC
- alloc_pred_valid  in  1  BPU prediction was valid for this PC
- alloc_pred_taken  in  1  BPU predicted direction
- alloc_tag  out  TAG_W  tag assigned to the current allocation (tail index)
- resolve_valid  in  1  execute resolved a branch
- resolve_tag  in  TAG_W  entry being resolved
- resolve_taken  in  1  actual direction
- flush  in  1  discard all entries
- update_valid  out  1  BPU update strobe, one cycle
- update_addr  out  32  PC being trained
- update_taken  out  1  actual direction
- mispredict_valid  out  1  retired entry was mispredicted, one cycle
- mispredict_addr  out  32  PC of the mispredicted branch
- count  out  TAG_W+1  occupied entries

## Operation
- Storage: circular buffer, one entry per slot. Fields per entry: addr, pred_valid, pred_taken, resolved, taken, busy.
- Pointers: head and tail, each TAG_W+1 bits wide (extra wrap bit).
  - Empty: head == tail.
  - Full: low bits equal and wrap bits differ.
- Allocate:
  - alloc_ready = !full, decoded from registered state.
  - On an accepted allocation, write the slot at tail, set busy=1 and resolved=0, then increment tail.
  - alloc_tag = tail[TAG_W-1:0] at all times.
- Resolve:
  - If the slot at resolve_tag is busy, set resolved=1 and taken=resolve_taken.
  - If the slot is not busy, the resolve is ignored.
  - Resolving an already-resolved slot overwrites taken.
- Retire:
  - Condition: the head slot is busy and resolved (registered state only).
  - At most one retire per cycle. Clear busy and increment head.
  - Registered outputs on the next edge:
    - update_valid=1, update_addr=addr, update_taken=taken.
    - Mispredict condition: taken != (pred_valid & pred_taken). When true, also mispredict_valid=1 and mispredict_addr=addr.
- Predicted direction for an entry with pred_valid=0 is not-taken.
- The queue never flushes itself. The core responds to mispredict_valid by asserting flush.
- Flush:
  - Clears all busy bits and sets head = tail = 0.
  - Suppresses that cycle's allocate, resolve and retire, so no update is emitted.
  - update/mispredict outputs registered on the previous edge still complete normally.
- Simultaneous events:
  - Allocate and retire in the same cycle are allowed. count is unchanged.
  - A retire in a cycle where the queue is full does not raise alloc_ready until the next cycle.
  - A resolve of the head slot takes effect the cycle after; there is no bypass into retire.

## Timing
- Reset: update_valid=0, update_addr=0, update_taken=0, mispredict_valid=0, mispredict_addr=0, count=0, head=tail=0, all busy=0.
  - First cycle after reset: alloc_ready=1, alloc_tag=0.
- Allocation lands at edge t; the entry is visible from cycle t+1.
- Resolve sampled at edge t, head retire evaluated in cycle t+1, update_valid high in cycle t+2. Minimum latency from resolve to update is 2 cycles.
- Back-to-back resolved entries retire on consecutive cycles, at one update per cycle.
- count and alloc_ready are derived from registered pointers and have no combinational path from the alloc_* or resolve_* inputs.
- Reset mid-operation discards all entries. No update is emitted after reset.

## Structure
- Shared package bpu_pkg holds:
  - brq_entry_t struct with addr, pred_valid, pred_taken, resolved, taken, busy.
  - BRQ_DEPTH default constant.
- Single module. No sub-module: storage is an array of brq_entry_t inside the block.

## Test plan
All scenarios use DEPTH=4.
- Reset → alloc_ready=1, alloc_tag=0, count=0, update_valid=0, mispredict_valid=0.
- Alloc 0x100 (pred_valid=1, pred_taken=1) → tag 0. Resolve tag 0 taken=1 at edge t → cycle t+2: update_valid=1, update_addr=0x100, update_taken=1, mispredict_valid=0.
- Alloc 0x200 (tag 0) and 0x204 (tag 1). Resolve tag 1, then tag 0 → no update until tag 0 resolves; then updates for 0x200 and 0x204 on consecutive cycles.
- Alloc 4 entries → count=4, alloc_ready=0; a 5th alloc_valid is ignored. Resolve and retire tag 0 → alloc_ready=1 the cycle after the retire; the next alloc gets tag 0 (wrap).
- Alloc 0x300 with pred_valid=0, resolve taken=1 → update_taken=1, mispredict_valid=1, mispredict_addr=0x300 in the same cycle.
- 3 entries with head resolved; assert flush in the cycle the head would retire → no update_valid, count=0 the next cycle, next alloc_tag=0.
